// File: rtl/dma_channel_arbiter.sv
// Round-robin front end sharing one DMA engine between NUM_CH channels.
// Latches the winner's size, pulses eng_start, tracks busy and returns done/err pulses.
module dma_channel_arbiter #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CH_W          = 2,
  parameter int unsigned SIZE_W        = 32,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*SIZE_W-1:0] ch_size,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     eng_start,
  output logic [SIZE_W-1:0]        eng_size,
  input  logic                     eng_busy,
  output logic                     active,
  output logic [CH_W-1:0]          active_ch
);

  localparam int unsigned TmrW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitBusy, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   err_q, err_d;
  logic                start_q, start_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                active_q, active_d;
  logic [CH_W-1:0]     active_ch_q, active_ch_d;

  logic                win_found;
  logic [CH_W-1:0]     win_idx;
  logic [CH_W-1:0]     cand_idx;
  logic [SIZE_W-1:0]   win_size;

  // Search starts one past the last grant; CH_W-bit addition wraps modulo NUM_CH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand_idx = last_grant_q + CH_W'(i);
      if (!win_found && ch_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_size = ch_size[win_idx*SIZE_W +: SIZE_W];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    ack_d        = '0;
    done_d       = '0;
    err_d        = '0;
    start_d      = 1'b0;
    size_d       = size_q;
    active_d     = active_q;
    active_ch_d  = active_ch_q;

    unique case (state_q)
      StIdle: begin
        active_d = 1'b0;
        if (win_found && !eng_busy) begin
          ack_d       = NUM_CH'(1) << win_idx;
          active_d    = 1'b1;
          active_ch_d = win_idx;
          size_d      = win_size;
          // A zero-byte transfer completes without touching the engine.
          state_d     = (win_size != '0) ? StLaunch : StDone;
        end
      end
      StLaunch: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (eng_busy) begin
          state_d = StRun;
        end else if (timer_q == TmrLast) begin
          err_d        = NUM_CH'(1) << active_ch_q;
          last_grant_d = active_ch_q;
          state_d      = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRun: begin
        if (!eng_busy) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d       = NUM_CH'(1) << active_ch_q;
        last_grant_d = active_ch_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= CH_W'(NUM_CH - 1);
      timer_q      <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      start_q      <= 1'b0;
      size_q       <= '0;
      active_q     <= 1'b0;
      active_ch_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_q      <= start_d;
      size_q       <= size_d;
      active_q     <= active_d;
      active_ch_q  <= active_ch_d;
    end
  end

  assign ch_ack    = ack_q;
  assign ch_done   = done_q;
  assign ch_err    = err_q;
  assign eng_start = start_q;
  assign eng_size  = size_q;
  assign active    = active_q;
  assign active_ch = active_ch_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter with a behavioural engine model.
module tb_dma_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  localparam int SIZE_W = 32;
  localparam int START_TIMEOUT = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*SIZE_W-1:0] ch_size;
  logic [NUM_CH-1:0]        ch_ack, ch_done, ch_err;
  logic                     eng_start;
  logic [SIZE_W-1:0]        eng_size;
  logic                     eng_busy;
  logic                     active;
  logic [CH_W-1:0]          active_ch;

  dma_channel_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SIZE_W(SIZE_W), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_size(ch_size), .ch_ack(ch_ack),
    .ch_done(ch_done), .ch_err(ch_err), .eng_start(eng_start), .eng_size(eng_size),
    .eng_busy(eng_busy), .active(active), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 ack, 1 done, 2 err
    int ch;
    int size;
    int dt;    // cycles after ack, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_ack_cyc = 0;
  int  start_cnt = 0;
  int  req_tgt[NUM_CH];
  int  ack_seen[NUM_CH];
  int  eng_len = 4;
  bit  eng_never = 1'b0;
  bit  start_seen = 1'b0;
  int  eng_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Requests stay up until the bench has seen the wanted number of acks.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_req[i] = (req_tgt[i] > ack_seen[i]);
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine registers start, then stays busy for eng_len cycles.
  initial begin
    eng_busy = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = eng_start;
      @(posedge clk);
      #1;
      if (rst) begin
        eng_busy = 1'b0;
        eng_cnt  = 0;
      end else if (start_seen && !eng_never) begin
        eng_busy = 1'b1;
        eng_cnt  = eng_len;
      end else if (eng_busy) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_busy = 1'b0;
      end
    end
  end

  function automatic int idx_of(input logic [NUM_CH-1:0] v);
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic handle(input int kind, input logic [NUM_CH-1:0] vec);
    ev_t e;
    int  ch;
    ch = idx_of(vec);
    check_eq("pulse_onehot", 64'($onehot(vec)), 1);
    if (exp_q.size() == 0) begin
      check_eq("unexpected_event", 64'(vec), 0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("ev_kind", kind, e.kind);
    check_eq("ev_ch", ch, e.ch);
    check_eq("active_during_ev", 64'(active), 1);
    if (kind == 0) begin
      last_ack_cyc = cyc;
      check_eq("eng_size", 64'(eng_size), e.size);
      check_eq("active_ch", 64'(active_ch), ch);
      if (ch >= 0) ack_seen[ch]++;
    end else if (e.dt >= 0) begin
      check_eq("ev_latency", cyc - last_ack_cyc, e.dt);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) continue;
    if (eng_start) begin
      start_cnt++;
      check_eq("start_latency", cyc - last_ack_cyc, 1);
    end
    if (|ch_ack)  handle(0, ch_ack);
    if (|ch_done) handle(1, ch_done);
    if (|ch_err)  handle(2, ch_err);
  end

  task automatic push(input int kind, input int ch, input int size, input int dt);
    ev_t e;
    e.kind = kind; e.ch = ch; e.size = size; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic set_size(input int ch, input int s);
    ch_size[ch*SIZE_W +: SIZE_W] = s;
  endtask

  task automatic request(input int ch, input int n);
    req_tgt[ch] = ack_seen[ch] + n;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_eq({tag, "_idle"}, 64'(active), 0);
  endtask

  initial begin
    int s0;
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    ch_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_tgt[i] = 0;
      ack_seen[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             64'({ch_ack, ch_done, ch_err, eng_start, active, active_ch, eng_size}), 0);
    rst = 1'b0;
    @(negedge clk);

    // All channels held: ch0 wants two grants, so order must be 0,1,2,3,0.
    for (int i = 0; i < NUM_CH; i++) set_size(i, 8);
    eng_len = 3;
    for (int i = 0; i < 5; i++) begin
      push(0, order[i], 8, -1);
      push(1, order[i], 0, 4 + 3);
    end
    request(0, 2); request(1, 1); request(2, 1); request(3, 1);
    drain("rr_all", 400);

    // Wrap: after ch2, ch0 beats ch1.
    push(0, 2, 8, -1); push(1, 2, 0, 7);
    request(2, 1);
    drain("rr_ch2", 100);
    push(0, 0, 8, -1); push(1, 0, 0, 7); push(0, 1, 8, -1); push(1, 1, 0, 7);
    request(0, 1); request(1, 1);
    drain("rr_wrap", 200);

    // Single 16-byte request, engine busy 8 cycles.
    set_size(0, 16);
    eng_len = 8;
    s0 = start_cnt;
    push(0, 0, 16, -1); push(1, 0, 0, 12);
    request(0, 1);
    drain("single", 100);
    check_eq("single_starts", start_cnt - s0, 1);

    // Zero size completes the cycle after ack without an engine start.
    set_size(1, 0);
    s0 = start_cnt;
    push(0, 1, 0, -1); push(1, 1, 0, 1);
    request(1, 1);
    drain("zero_size", 50);
    check_eq("zero_starts", start_cnt - s0, 0);

    // Engine never responds: both channels time out in turn.
    eng_never = 1'b1;
    set_size(2, 5); set_size(3, 7);
    push(0, 2, 5, -1); push(2, 2, 0, 9); push(0, 3, 7, -1); push(2, 3, 0, 9);
    request(2, 1); request(3, 1);
    drain("timeout", 100);
    eng_never = 1'b0;

    // Reset in the middle of a running transfer.
    set_size(1, 4);
    eng_len = 50;
    push(0, 1, 4, -1);
    request(1, 1);
    s0 = 0;
    while (!eng_busy && s0 < 20) begin
      @(negedge clk);
      s0++;
    end
    check_eq("busy_seen", 64'(eng_busy), 1);
    repeat (3) @(negedge clk);
    check_eq("q_before_rst", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_outputs",
             64'({ch_ack, ch_done, ch_err, eng_start, active, active_ch, eng_size}), 0);
    request(3, 1);
    eng_len = 5;
    push(0, 3, 7, -1); push(1, 3, 0, 9);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_first_ack", 64'(ch_ack), 64'(4'b1000));
    drain("rst_recover", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
Multi-channel front end that shares the single DMA transfer engine between NUM_CH requesting channels. It arbitrates requests round-robin and latches the winner's transfer size. It launches the engine with a one-cycle start pulse, tracks the engine busy window, and returns per-channel done/error pulses. It sits between channel request logic and the engine's start/size/busy interface.

Parameters:
NUM_CH, 4, number of requesting channels; power of 2, >=2
CH_W, 2, channel index width = log2(NUM_CH)
SIZE_W, 32, transfer size width in bytes
START_TIMEOUT, 8, cycles to wait for eng_busy after start before declaring error; >=2

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
ch_req  in  NUM_CH  level request per channel
ch_size  in  NUM_CH*SIZE_W  per-channel size; channel i in bits [i*SIZE_W +: SIZE_W]
ch_ack  out  NUM_CH  one-cycle pulse: request captured, size latched
ch_done  out  NUM_CH  one-cycle pulse: transfer complete
ch_err  out  NUM_CH  one-cycle pulse: engine failed to start
eng_start  out  1  one-cycle start pulse to engine
eng_size  out  SIZE_W  latched size, stable from ack until next grant
eng_busy  in  1  engine busy flag
active  out  1  high from grant until done/err cycle inclusive
active_ch  out  CH_W  index of granted channel, held until next grant

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=NUM_CH-1, so ch0 has top priority first; timer 0. Reset mid-operation aborts with no done/err pulse.
- All outputs are registered. ch_ack/ch_done/ch_err are one-hot or zero, never more than one bit set.
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, DONE.
- IDLE:
  - Grants only if |ch_req and eng_busy==0.
  - Winner is the first requesting channel searching from last_grant+1 upward, wrapping modulo NUM_CH.
  - On the grant edge: ch_ack[w]<=1, active<=1, active_ch<=w, eng_size<=ch_size[w].
  - Next state is LAUNCH if the size is nonzero. If the size is 0, go to DONE (no engine activity, success).
- LAUNCH: eng_start<=1 for exactly one cycle; timer<=0; next WAIT_BUSY.
- WAIT_BUSY:
  - If eng_busy==1, go to RUN.
  - Otherwise timer++. When timer==START_TIMEOUT-1 without busy: ch_err[active_ch]<=1, last_grant<=active_ch, active<=0 on the following edge, then IDLE.
- RUN: waits for eng_busy==0, then DONE. No timeout applies in RUN.
- DONE: ch_done[active_ch]<=1 for one cycle; last_grant<=active_ch; active<=0 on exit; next IDLE.
- Latency:
  - Request sampled at edge k gives ch_ack high in cycle k..k+1.
  - eng_start high in cycle k+1..k+2.
  - Engine busy is first seen at edge k+3.
  - ch_done rises one edge after busy is sampled low.
  - Minimum gap between done and the next ack is 1 cycle (the IDLE re-arbitration edge).
- ch_req is level-sensitive. A requester deasserts after ch_ack; a request still held when IDLE is re-entered is treated as a new request. Requests asserted during a transfer are not lost.
- Fairness: a channel holding req continuously is granted within NUM_CH grants.
- ch_req changes while not in IDLE are ignored; ch_size is only sampled on the grant edge.

Test Plan:
- Single request: ch_req=4'b0001, ch_size[0]=16, engine model busy for 8 cycles → ack[0] one cycle, eng_start one cycle, eng_size=16, done[0] one cycle after busy falls, active_ch=0.
- Simultaneous: ch_req=4'b1111 held, all sizes=8 → grant order 0,1,2,3,0; no two ack bits ever set together.
- Round-robin wrap: after ch2 granted, ch_req=4'b0011 → ch0 granted next, not ch1.
- Zero size: ch_size[1]=0, ch_req=4'b0010 → ack[1], done[1] the next cycle, eng_start never asserted.
- Start timeout: engine model never asserts busy, START_TIMEOUT=8 → err[k] pulse, no done, back to IDLE, next channel serviced.
- Reset mid-RUN: assert rst during busy → all outputs 0 immediately; after release, pending req on ch3 granted (ch0..ch2 idle) with ack at the first sampled edge.
